// File: rtl/if_fetch_sequencer.sv
// IF-stage fetch sequencer: owns the PC write strobe, the instruction-memory request,
// fetch redirects (branch/jump/exception), a one-entry stall buffer and a fetch timeout.
module if_fetch_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic        _clk,
   input  logic        _reset,
   input  logic        stall_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   input  logic        exc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic        pc_write_o,
   output logic [31:0] pc_next_o,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   output logic        flush_o,
   output logic        fetch_err_o
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   function automatic logic [31:0] align_word(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   state_t      state_r, state_nxt_s;
   logic        req_r, pcw_r, valid_r, flush_r, err_r, discard_r;
   logic [31:0] addr_r, pc_r, instr_r, buf_instr_r, buf_pc_r, tgt_r;
   logic [7:0]  wait_cnt_r;

   logic        req_d_s, pcw_d_s, valid_d_s, flush_d_s, err_d_s, discard_d_s;
   logic [31:0] addr_d_s, pc_d_s, instr_d_s, buf_instr_d_s, buf_pc_d_s, tgt_d_s;
   logic [7:0]  wait_cnt_d_s;
   logic        redir_s;
   logic [31:0] redir_tgt_s;

   // Redirect decode: exception beats jump beats branch; only an exception leaves ERR.
   always_comb begin
      if (exc_i) begin
         redir_tgt_s = align_word(EXC_VECTOR);
      end else if (jump_i) begin
         redir_tgt_s = align_word(jump_target_i);
      end else begin
         redir_tgt_s = align_word(branch_target_i);
      end
      if (state_r == ST_ERR) begin
         redir_s = exc_i;
      end else begin
         redir_s = exc_i | jump_i | branch_taken_i;
      end
   end

   // State register
   always_ff @(posedge _clk or posedge _reset) begin
      if (_reset) begin
         state_r <= ST_BOOT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_BOOT:  state_nxt_s = ST_FETCH;
         ST_FETCH: begin
            if (redir_s) begin
               state_nxt_s = ST_FETCH;
            end else if (imem_ack_i) begin
               state_nxt_s = (stall_i && !discard_r) ? ST_HOLD : ST_FETCH;
            end else if (wait_cnt_r == TIMEOUT_LAST) begin
               state_nxt_s = ST_ERR;
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         ST_HOLD: begin
            if (redir_s || !stall_i) begin
               state_nxt_s = ST_FETCH;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         ST_ERR: begin
            if (redir_s) begin
               state_nxt_s = ST_FETCH;
            end else begin
               state_nxt_s = ST_ERR;
            end
         end
         default: state_nxt_s = ST_BOOT;
      endcase
   end

   // Output and datapath next values; everything holds unless a rule below fires
   always_comb begin
      req_d_s       = (state_nxt_s == ST_FETCH);
      addr_d_s      = addr_r;
      pcw_d_s       = 1'b0;
      flush_d_s     = 1'b0;
      valid_d_s     = valid_r;
      instr_d_s     = instr_r;
      pc_d_s        = pc_r;
      buf_instr_d_s = buf_instr_r;
      buf_pc_d_s    = buf_pc_r;
      tgt_d_s       = tgt_r;
      discard_d_s   = discard_r;
      wait_cnt_d_s  = wait_cnt_r;
      err_d_s       = err_r;
      if (redir_s) begin
         flush_d_s    = 1'b1;
         valid_d_s    = 1'b0;
         wait_cnt_d_s = 8'd0;
         tgt_d_s      = redir_tgt_s;
         // An unanswered request cannot be withdrawn: drop its data when it lands.
         if ((state_r == ST_FETCH) && !imem_ack_i) begin
            discard_d_s = 1'b1;
         end else begin
            addr_d_s    = redir_tgt_s;
            pcw_d_s     = 1'b1;
            discard_d_s = 1'b0;
         end
      end else begin
         case (state_r)
            ST_BOOT: pcw_d_s = 1'b1;
            ST_FETCH: begin
               if (imem_ack_i) begin
                  wait_cnt_d_s = 8'd0;
                  if (discard_r) begin
                     discard_d_s = 1'b0;
                     addr_d_s    = tgt_r;
                     pcw_d_s     = 1'b1;
                     valid_d_s   = 1'b0;
                  end else if (stall_i) begin
                     buf_instr_d_s = imem_data_i;
                     buf_pc_d_s    = addr_r;
                  end else begin
                     instr_d_s = imem_data_i;
                     pc_d_s    = addr_r;
                     valid_d_s = 1'b1;
                     addr_d_s  = addr_r + 32'd4;
                     pcw_d_s   = 1'b1;
                  end
               end else begin
                  wait_cnt_d_s = wait_cnt_r + 8'd1;
                  if (wait_cnt_r == TIMEOUT_LAST) begin
                     err_d_s   = 1'b1;
                     valid_d_s = 1'b0;
                  end else if (!stall_i) begin
                     valid_d_s = 1'b0;
                  end else begin
                     valid_d_s = valid_r;
                  end
               end
            end
            ST_HOLD: begin
               if (!stall_i) begin
                  instr_d_s = buf_instr_r;
                  pc_d_s    = buf_pc_r;
                  valid_d_s = 1'b1;
                  addr_d_s  = buf_pc_r + 32'd4;
                  pcw_d_s   = 1'b1;
               end else begin
                  valid_d_s = valid_r;
               end
            end
            ST_ERR:  valid_d_s = 1'b0;
            default: valid_d_s = 1'b0;
         endcase
      end
   end

   // Registered outputs and datapath state
   always_ff @(posedge _clk or posedge _reset) begin
      if (_reset) begin
         req_r       <= 1'b0;
         addr_r      <= RESET_PC;
         pcw_r       <= 1'b0;
         flush_r     <= 1'b0;
         valid_r     <= 1'b0;
         instr_r     <= 32'd0;
         pc_r        <= RESET_PC;
         buf_instr_r <= 32'd0;
         buf_pc_r    <= RESET_PC;
         tgt_r       <= RESET_PC;
         discard_r   <= 1'b0;
         wait_cnt_r  <= 8'd0;
         err_r       <= 1'b0;
      end else begin
         req_r       <= req_d_s;
         addr_r      <= addr_d_s;
         pcw_r       <= pcw_d_s;
         flush_r     <= flush_d_s;
         valid_r     <= valid_d_s;
         instr_r     <= instr_d_s;
         pc_r        <= pc_d_s;
         buf_instr_r <= buf_instr_d_s;
         buf_pc_r    <= buf_pc_d_s;
         tgt_r       <= tgt_d_s;
         discard_r   <= discard_d_s;
         wait_cnt_r  <= wait_cnt_d_s;
         err_r       <= err_d_s;
      end
   end

   assign imem_req_o    = req_r;
   assign imem_addr_o   = addr_r;
   assign pc_next_o     = addr_r;
   assign pc_write_o    = pcw_r;
   assign flush_o       = flush_r;
   assign instr_valid_o = valid_r;
   assign instr_o       = instr_r;
   assign pc_o          = pc_r;
   assign fetch_err_o   = err_r;

endmodule
